// File: rtl/render_cmd_master.sv
// Avalon-MM master that replays queued draw commands as renderer register writes
// and implements a frame-flip barrier by polling the renderer's parity register.
module render_cmd_master #(
  parameter int FIFO_DEPTH = 8,
  parameter int POLL_GAP   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [9:0]                  cmd_x,
  input  logic [8:0]                  cmd_y,
  input  logic [6:0]                  cmd_tex,
  input  logic                        sync_req,
  output logic                        sync_done,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [3:0]                  master_address,
  output logic                        master_write,
  output logic [31:0]                 master_writedata,
  output logic                        master_read,
  input  logic [31:0]                 master_readdata,
  input  logic                        master_waitrequest
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(POLL_GAP) + 1;

  localparam logic [3:0] REG_MID_X  = 4'd1;
  localparam logic [3:0] REG_MID_Y  = 4'd2;
  localparam logic [3:0] REG_TEX    = 4'd4;
  localparam logic [3:0] REG_PARITY = 4'd5;
  localparam logic [3:0] REG_PLOT   = 4'd6;

  typedef enum logic [3:0] {
    IDLE, LOAD, WR_X, WR_Y, WR_TEX, WR_GO,
    SYNC_RD0, SYNC_CAP0, SYNC_GAP, SYNC_RD1, SYNC_CHK
  } state_t;

  state_t          state, state_nxt;
  logic [25:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop;
  logic [9:0]      head_x, work_x, shadow_x;
  logic [8:0]      head_y, work_y, shadow_y;
  logic [6:0]      head_tex, work_tex;
  logic            shadow_x_vld, shadow_y_vld;
  logic            sync_pending, base;
  logic [GW-1:0]   gap_cnt;
  logic            accept;

  // Only bit 0 of the read bus (frame parity) carries information.
  logic unused_readdata;
  assign unused_readdata = ^master_readdata[31:1];

  assign accept    = !master_waitrequest;
  assign cmd_ready = (count < CW'(FIFO_DEPTH)) && !sync_pending;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == LOAD);
  assign fifo_count = count;
  assign {head_x, head_y, head_tex} = mem[rd_ptr];

  // NOTE: FIFO storage has no reset; emptiness is defined by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_x, cmd_y, cmd_tex};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt        = state;
    master_write     = 1'b0;
    master_read      = 1'b0;
    master_address   = 4'd0;
    master_writedata = 32'd0;
    sync_done        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0)       state_nxt = LOAD;
        else if (sync_pending) state_nxt = SYNC_RD0;
      end
      LOAD: begin
        if (head_tex[6])                                state_nxt = WR_TEX;
        else if (!(shadow_x_vld && head_x == shadow_x)) state_nxt = WR_X;
        else if (!(shadow_y_vld && head_y == shadow_y)) state_nxt = WR_Y;
        else                                            state_nxt = WR_TEX;
      end
      WR_X: begin
        master_write     = 1'b1;
        master_address   = REG_MID_X;
        master_writedata = {{22{work_x[9]}}, work_x};
        if (accept) state_nxt = (shadow_y_vld && work_y == shadow_y) ? WR_TEX : WR_Y;
      end
      WR_Y: begin
        master_write     = 1'b1;
        master_address   = REG_MID_Y;
        master_writedata = {{23{work_y[8]}}, work_y};
        if (accept) state_nxt = WR_TEX;
      end
      WR_TEX: begin
        master_write     = 1'b1;
        master_address   = REG_TEX;
        master_writedata = {25'd0, work_tex};
        if (accept) state_nxt = WR_GO;
      end
      WR_GO: begin
        master_write   = 1'b1;
        master_address = REG_PLOT;
        if (accept) state_nxt = IDLE;
      end
      SYNC_RD0: begin
        master_read    = 1'b1;
        master_address = REG_PARITY;
        if (accept) state_nxt = SYNC_CAP0;
      end
      SYNC_CAP0: state_nxt = SYNC_GAP;
      SYNC_GAP: begin
        if (gap_cnt == GW'(POLL_GAP - 1)) state_nxt = SYNC_RD1;
      end
      SYNC_RD1: begin
        master_read    = 1'b1;
        master_address = REG_PARITY;
        if (accept) state_nxt = SYNC_CHK;
      end
      SYNC_CHK: begin
        if (master_readdata[0] != base) begin
          sync_done = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = SYNC_GAP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = !((state == IDLE && count == '0 && !sync_pending) || sync_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      work_x       <= '0;
      work_y       <= '0;
      work_tex     <= '0;
      shadow_x     <= '0;
      shadow_y     <= '0;
      shadow_x_vld <= 1'b0;
      shadow_y_vld <= 1'b0;
      sync_pending <= 1'b0;
      base         <= 1'b0;
      gap_cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) begin
        work_x   <= head_x;
        work_y   <= head_y;
        work_tex <= head_tex;
      end
      // Shadows track what the renderer actually holds, so update only on acceptance.
      if (state == WR_X && accept) begin
        shadow_x     <= work_x;
        shadow_x_vld <= 1'b1;
      end
      if (state == WR_Y && accept) begin
        shadow_y     <= work_y;
        shadow_y_vld <= 1'b1;
      end
      if (sync_done)     sync_pending <= 1'b0;
      else if (sync_req) sync_pending <= 1'b1;
      if (state == SYNC_CAP0) base <= master_readdata[0];
      gap_cnt <= (state == SYNC_GAP) ? gap_cnt + GW'(1) : '0;
    end
  end
endmodule

// File: tb/tb_render_cmd_master.sv
// Directed bench for render_cmd_master: table of command vectors plus hand-written
// stall, frame-sync and mid-transaction reset sequences against a simple slave model.
module tb_render_cmd_master;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic [6:0]  cmd_tex;
  logic        sync_req, sync_done, busy;
  logic [3:0]  fifo_count;
  logic [3:0]  master_address;
  logic        master_write, master_read;
  logic [31:0] master_writedata, master_readdata;
  logic        master_waitrequest;
  logic        parity;

  render_cmd_master #(.FIFO_DEPTH(8), .POLL_GAP(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_tex(cmd_tex),
    .sync_req(sync_req), .sync_done(sync_done), .busy(busy), .fifo_count(fifo_count),
    .master_address(master_address), .master_write(master_write),
    .master_writedata(master_writedata), .master_read(master_read),
    .master_readdata(master_readdata), .master_waitrequest(master_waitrequest)
  );

  // Slave returns the current frame parity on every read.
  assign master_readdata = {31'd0, parity};

  always #10 clk = ~clk;

  typedef struct packed {
    logic [9:0]       x;
    logic [8:0]       y;
    logic [6:0]       tex;
    logic [2:0]       n;
    logic [3:0][3:0]  a;
    logic [3:0][31:0] d;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          c;
  } xfer_t;

  int    n_vec = 0, n_miss = 0;
  int    cyc = 0;
  xfer_t wlog[$];
  int    rlog[$];
  int    bad_raddr = 0, both_hi = 0, done_cnt = 0;
  logic  stab_en = 1'b0;
  logic  held = 1'b0;
  logic [3:0]  h_addr;
  logic [31:0] h_data;
  vec_t  vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor, sampled mid-cycle: log accepted transfers and check stalled writes hold.
  always @(negedge clk) begin
    if (master_write && !master_waitrequest) wlog.push_back('{master_address, master_writedata, cyc});
    if (master_read && !master_waitrequest) begin
      rlog.push_back(cyc);
      if (master_address != 4'd5) bad_raddr++;
    end
    if (master_read && master_write) both_hi++;
    if (sync_done) done_cnt++;
    if (stab_en && held) begin
      check("stall write held", master_write, 1'b1);
      check("stall addr stable", master_address, h_addr);
      check("stall data stable", master_writedata, h_data);
    end
    held   <= master_write && master_waitrequest;
    h_addr <= master_address;
    h_data <= master_writedata;
  end

  function automatic vec_t mk(input int x, input int y, input int t, input int n,
                              input logic [3:0] a0, input logic [31:0] d0,
                              input logic [3:0] a1, input logic [31:0] d1,
                              input logic [3:0] a2, input logic [31:0] d2,
                              input logic [3:0] a3, input logic [31:0] d3);
    vec_t v;
    v.x = 10'(x); v.y = 9'(y); v.tex = 7'(t); v.n = 3'(n);
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    return v;
  endfunction

  task automatic push(input logic [9:0] x, input logic [8:0] y, input logic [6:0] t, output int pc);
    int guard = 0;
    @(posedge clk); #1;
    cmd_x = x; cmd_y = y; cmd_tex = t; cmd_valid = 1'b1;
    while (!cmd_ready && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 5000) check("push ready timeout", cmd_ready, 1'b1);
    @(posedge clk); #1;
    pc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || fifo_count != 0) && n < limit);
    check({tag, " idle"}, busy, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int pc;
    wlog.delete();
    push(v.x, v.y, v.tex, pc);
    wait_idle(2000, tag);
    check({tag, " n_writes"}, wlog.size(), 32'(v.n));
    if (wlog.size() > 0) check({tag, " first write latency"}, wlog[0].c - pc, 2);
    for (int k = 0; k < int'(v.n) && k < wlog.size(); k++) begin
      check($sformatf("%s w%0d addr", tag, k), wlog[k].addr, v.a[k]);
      check($sformatf("%s w%0d data", tag, k), wlog[k].data, v.d[k]);
      if (k > 0) check($sformatf("%s w%0d back-to-back", tag, k), wlog[k].c - wlog[k-1].c, 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, %0d miscompares so far", n_miss);
    $fatal(1);
  end

  initial begin
    int pc, min_gap;
    logic ready_seen;
    int n;

    vt[0] = mk(100, 50, 2, 4,      1, 32'd100,      2, 32'd50,       4, 32'd2,    6, 0);
    vt[1] = mk(100, 50, 3, 2,      4, 32'd3,        6, 0,            0, 0,        0, 0);
    vt[2] = mk(100, 50, 4, 2,      4, 32'd4,        6, 0,            0, 0,        0, 0);
    vt[3] = mk(-5, -3, 1, 4,       1, 32'hFFFFFFFB, 2, 32'hFFFFFFFD, 4, 32'd1,    6, 0);
    vt[4] = mk(7, -3, 'h45, 2,     4, 32'h45,       6, 0,            0, 0,        0, 0);
    vt[5] = mk(-5, -3, 9, 2,       4, 32'd9,        6, 0,            0, 0,        0, 0);
    vt[6] = mk(-5, 20, 9, 3,       2, 32'd20,       4, 32'd9,        6, 0,        0, 0);
    vt[7] = mk(0, 20, 0, 3,        1, 32'd0,        4, 32'd0,        6, 0,        0, 0);
    vt[8] = mk(-512, -256, 'h3F, 4, 1, 32'hFFFFFE00, 2, 32'hFFFFFF00, 4, 32'h3F,  6, 0);
    vt[9] = mk(511, 255, 'h3F, 4,  1, 32'h1FF,      2, 32'hFF,       4, 32'h3F,   6, 0);

    reset = 1'b1; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_tex = '0;
    sync_req = 1'b0; master_waitrequest = 1'b0; parity = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("reset master_write", master_write, 1'b0);
    check("reset master_read", master_read, 1'b0);
    check("reset master_address", master_address, 4'd0);
    check("reset master_writedata", master_writedata, 32'd0);
    check("reset sync_done", sync_done, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset fifo_count", fifo_count, 4'd0);
    check("reset cmd_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Nine commands against a stalled slave: one sits in WR_X, eight fill the FIFO.
    master_waitrequest = 1'b1;
    stab_en = 1'b1;
    wlog.delete();
    for (int i = 0; i < 9; i++) push(10'(i + 1), 9'(-(i + 1)), 7'(i), pc);
    check("stall fifo_count full", fifo_count, 4'd8);
    check("stall cmd_ready low", cmd_ready, 1'b0);
    check("stall write addr", master_address, 4'd1);
    check("stall write data", master_writedata, 32'd1);
    cmd_x = 10'd99; cmd_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("stall no push when full", fifo_count, 4'd8);
    cmd_valid = 1'b0;
    master_waitrequest = 1'b0;
    wait_idle(2000, "stall drain");
    stab_en = 1'b0;
    check("stall n_writes", wlog.size(), 36);
    for (int i = 0; i < 9 && wlog.size() == 36; i++) begin
      check($sformatf("stall c%0d x addr", i), wlog[4*i].addr, 4'd1);
      check($sformatf("stall c%0d x data", i), wlog[4*i].data, 32'(i + 1));
      check($sformatf("stall c%0d y addr", i), wlog[4*i+1].addr, 4'd2);
      check($sformatf("stall c%0d y data", i), wlog[4*i+1].data, 32'(-(i + 1)));
      check($sformatf("stall c%0d tex addr", i), wlog[4*i+2].addr, 4'd4);
      check($sformatf("stall c%0d tex data", i), wlog[4*i+2].data, 32'(i));
      check($sformatf("stall c%0d go addr", i), wlog[4*i+3].addr, 4'd6);
      check($sformatf("stall c%0d go data", i), wlog[4*i+3].data, 32'd0);
    end

    // Frame sync: two queued commands drain, then parity polling until the flip.
    parity = 1'b0;
    wlog.delete(); rlog.delete();
    done_cnt = 0; bad_raddr = 0;
    push(10'd30, 9'd40, 7'd5, pc);
    push(10'd31, 9'd41, 7'd6, pc);
    @(posedge clk); #1 sync_req = 1'b1;
    @(posedge clk); #1 sync_req = 1'b0;
    check("sync cmd_ready blocked", cmd_ready, 1'b0);
    fork
      begin
        repeat (500) @(posedge clk);
        #1 parity = 1'b1;
      end
      begin
        repeat (100) @(posedge clk);
        #1 sync_req = 1'b1;
        @(posedge clk); #1 sync_req = 1'b0;
      end
    join_none
    n = 0; ready_seen = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (cmd_ready) ready_seen = 1'b1;
    end while (!sync_done && n < 3000);
    check("sync_done seen", sync_done, 1'b1);
    check("sync busy low at done", busy, 1'b0);
    check("sync cmd_ready low until done", ready_seen, 1'b0);
    repeat (150) @(negedge clk);
    check("sync_done single pulse", done_cnt, 1);
    check("sync cmd_ready restored", cmd_ready, 1'b1);
    check("sync busy after", busy, 1'b0);
    check("sync n_writes", wlog.size(), 8);
    check("sync drain before poll", (wlog.size() == 8 && rlog.size() > 0 && rlog[0] > wlog[7].c), 1'b1);
    check("sync poll count >= 2", rlog.size() >= 2, 1'b1);
    check("sync read address", bad_raddr, 0);
    min_gap = 1000000;
    for (int k = 1; k < rlog.size(); k++)
      if (rlog[k] - rlog[k-1] < min_gap) min_gap = rlog[k] - rlog[k-1];
    check("sync poll spacing", min_gap >= 17, 1'b1);
    if (wlog.size() == 8) begin
      check("sync c0 x", wlog[0].data, 32'd30);
      check("sync c0 y", wlog[1].data, 32'd40);
      check("sync c1 x", wlog[4].data, 32'd31);
      check("sync c1 tex", wlog[6].data, 32'd6);
    end

    // Reset while WR_Y is stalled: x matches the shadow, so the command starts at WR_Y.
    master_waitrequest = 1'b1;
    push(10'd31, 9'd99, 7'd7, pc);
    push(10'd31, 9'd99, 7'd8, pc);
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset write", master_write, 1'b1);
    check("pre-reset addr WR_Y", master_address, 4'd2);
    check("pre-reset fifo_count", fifo_count, 4'd1);
    #4 reset = 1'b1;
    #1;
    check("async reset write drop", master_write, 1'b0);
    check("async reset address", master_address, 4'd0);
    check("async reset fifo_count", fifo_count, 4'd0);
    check("async reset cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    master_waitrequest = 1'b0;
    run_vec(mk(31, 99, 7, 4, 1, 32'd31, 2, 32'd99, 4, 32'd7, 6, 0), "post-reset");
    check("bus read/write exclusive", both_hi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
